fifo_ctrl_single_clk: RTL and testbench

FIFO_CTRL_SINGLE_CLK -- requirements
Module: fifo_ctrl_single_clk

---
 rtl/fifo_ctrl_single_clk.sv | 112 +++++++++++
 tb/tb_fifo_ctrl_single_clk.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_single_clk.sv
// Single-clock FIFO controller: wrap-bit pointers, occupancy count, registered
// status flags, read-valid tracking and one-cycle overflow/underflow pulses.
module fifo_ctrl_single_clk #(
  parameter int unsigned SIZE_ADDR  = 4,
  parameter int unsigned SIZE_DEPTH = 16,
  parameter int unsigned AFULL_TH   = 14,
  parameter int unsigned AEMPTY_TH  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_req,
  input  logic                 i_rd_req,
  output logic                 o_wr_en,
  output logic                 o_rd_en,
  output logic [SIZE_ADDR-1:0] o_addr_wr,
  output logic [SIZE_ADDR-1:0] o_addr_rd,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [SIZE_ADDR:0]   o_count,
  output logic                 o_rd_valid,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam int unsigned CW = SIZE_ADDR + 1;

  generate
    if (SIZE_DEPTH != 2 ** SIZE_ADDR) begin : g_bad_depth
      $error("fifo_ctrl_single_clk: SIZE_DEPTH must equal 2**SIZE_ADDR");
    end
  endgenerate

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          rd_valid_q, rd_valid_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc, rd_acc;

  // Acceptance uses the flags registered before the edge; reset blocks both.
  assign wr_acc = i_wr_req & ~full_q & ~i_rst;
  assign rd_acc = i_rd_req & ~empty_q & ~i_rst;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + CW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + CW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Full when addresses match but the pointers are a lap apart.
    empty_d    = (wr_ptr_d == rd_ptr_d);
    full_d     = (wr_ptr_d[SIZE_ADDR-1:0] == rd_ptr_d[SIZE_ADDR-1:0]) &&
                 (wr_ptr_d[SIZE_ADDR] != rd_ptr_d[SIZE_ADDR]);
    afull_d    = (count_d >= CW'(AFULL_TH));
    aempty_d   = (count_d <= CW'(AEMPTY_TH));
    rd_valid_d = rd_acc;
    ovf_d      = i_wr_req & full_q;
    udf_d      = i_rd_req & empty_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign o_wr_en        = wr_acc;
  assign o_rd_en        = rd_acc;
  assign o_addr_wr      = wr_ptr_q[SIZE_ADDR-1:0];
  assign o_addr_rd      = rd_ptr_q[SIZE_ADDR-1:0];
  assign o_count        = count_q;
  assign o_full         = full_q;
  assign o_empty        = empty_q;
  assign o_almost_full  = afull_q;
  assign o_almost_empty = aempty_q;
  assign o_rd_valid     = rd_valid_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = udf_q;

endmodule

// File: tb/tb_fifo_ctrl_single_clk.sv
// Scoreboard bench for fifo_ctrl_single_clk: stimulus queues the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_fifo_ctrl_single_clk;

  logic       clk = 1'b0;
  logic       rst, wr_req, rd_req;
  logic       wr_en, rd_en, full, empty, afull, aempty, rd_valid, ovf, udf;
  logic [3:0] addr_wr, addr_rd;
  logic [4:0] count;

  typedef struct packed {
    logic       wr_en;
    logic       rd_en;
    logic [3:0] addr_wr;
    logic [3:0] addr_rd;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       afull;
    logic       aempty;
    logic       rd_valid;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: occupancy and total accepted writes/reads since reset.
  int m_occ, m_wcnt, m_rcnt;
  bit m_rdv, m_ovf, m_udf;

  always #5 clk = ~clk;

  fifo_ctrl_single_clk #(
    .SIZE_ADDR(4), .SIZE_DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_req(wr_req), .i_rd_req(rd_req),
    .o_wr_en(wr_en), .o_rd_en(rd_en), .o_addr_wr(addr_wr), .o_addr_rd(addr_rd),
    .o_full(full), .o_empty(empty), .o_almost_full(afull), .o_almost_empty(aempty),
    .o_count(count), .o_rd_valid(rd_valid), .o_overflow(ovf), .o_underflow(udf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_occ = 0; m_wcnt = 0; m_rcnt = 0;
    m_rdv = 0; m_ovf = 0; m_udf = 0;
  endtask

  // Called just after a rising edge: drive one cycle and queue its expectation.
  task automatic step(input bit r, input bit w, input bit rd);
    exp_t e;
    bit   m_full, m_empty, wacc, racc;
    rst = r; wr_req = w; rd_req = rd;
    m_full  = (m_occ == 16);
    m_empty = (m_occ == 0);
    wacc = w && !m_full && !r;
    racc = rd && !m_empty && !r;
    e.wr_en    = wacc;
    e.rd_en    = racc;
    e.addr_wr  = 4'(m_wcnt % 16);
    e.addr_rd  = 4'(m_rcnt % 16);
    e.count    = 5'(m_occ);
    e.full     = m_full;
    e.empty    = m_empty;
    e.afull    = (m_occ >= 14);
    e.aempty   = (m_occ <= 2);
    e.rd_valid = m_rdv;
    e.ovf      = m_ovf;
    e.udf      = m_udf;
    exp_q.push_back(e);
    if (r) model_reset();
    else begin
      m_ovf = w && m_full;
      m_udf = rd && m_empty;
      m_rdv = racc;
      if (wacc) begin m_wcnt++; m_occ++; end
      if (racc) begin m_rcnt++; m_occ--; end
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_en",    32'(wr_en),    32'(e.wr_en));
        check("rd_en",    32'(rd_en),    32'(e.rd_en));
        check("addr_wr",  32'(addr_wr),  32'(e.addr_wr));
        check("addr_rd",  32'(addr_rd),  32'(e.addr_rd));
        check("count",    32'(count),    32'(e.count));
        check("full",     32'(full),     32'(e.full));
        check("empty",    32'(empty),    32'(e.empty));
        check("afull",    32'(afull),    32'(e.afull));
        check("aempty",   32'(aempty),   32'(e.aempty));
        check("rd_valid", 32'(rd_valid), 32'(e.rd_valid));
        check("overflow", 32'(ovf),      32'(e.ovf));
        check("underflow",32'(udf),      32'(e.udf));
      end
    end
  end

  initial begin
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_aempty", 32'(aempty), 32'd1);
    check("rst_full", 32'(full), 32'd0);

    // Reset overrides requests
    step(1, 1, 1);
    step(1, 0, 0);

    // Fill 16
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0);
      if (i == 12) check("afull_at13", 32'(afull), 32'd0);
      if (i == 13) check("afull_at14", 32'(afull), 32'd1);
    end
    check("fill_count", 32'(count), 32'd16);
    check("fill_full", 32'(full), 32'd1);

    // Overflow
    step(0, 1, 0);
    check("ovf_pulse", 32'(ovf), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    step(0, 0, 0);
    check("ovf_end", 32'(ovf), 32'd0);

    // Drain 16, then underflow
    for (int i = 0; i < 16; i++) step(0, 0, 1);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_rdv_last", 32'(rd_valid), 32'd1);
    step(0, 0, 1);
    check("udf_pulse", 32'(udf), 32'd1);
    check("udf_rdv", 32'(rd_valid), 32'd0);
    step(0, 0, 0);

    // Simultaneous at 0, 5, 16
    step(0, 1, 1);
    check("sim0_count", 32'(count), 32'd1);
    check("sim0_rdv", 32'(rd_valid), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    step(0, 1, 1);
    check("sim5_count", 32'(count), 32'd5);
    for (int i = 0; i < 11; i++) step(0, 1, 0);
    check("pre16_full", 32'(full), 32'd1);
    step(0, 1, 1);
    check("sim16_count", 32'(count), 32'd15);
    for (int i = 0; i < 15; i++) step(0, 0, 1);
    step(0, 0, 0);

    // Interleaved 20/20 across pointer wrap, then full/empty past the wrap
    step(0, 1, 0);
    for (int i = 0; i < 19; i++) step(0, 1, 1);
    step(0, 0, 1);
    check("ilv_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    check("wrap_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) step(0, 0, 1);
    check("wrap_empty", 32'(empty), 32'd1);

    // Reset at count 7 with a read in flight
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    step(0, 0, 1);
    check("pre_rst_count", 32'(count), 32'd7);
    step(1, 0, 1);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_rdv", 32'(rd_valid), 32'd0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
